// File: rtl/lpm_scan_pkg.sv
// Shared definitions for the lpm_decode index scanner: state and mode encodings
// and the dwell counter width helper.
package lpm_scan_pkg;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_e;

    localparam logic SCAN_SINGLE = 1'b0;
    localparam logic SCAN_CONT   = 1'b1;

    // Bits needed to hold dwell-1; at least one bit so the counter always exists.
    function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/lpm_scan_dwell.sv
// Loadable dwell down-counter: load_i reloads DWELL-1, dec_i counts toward zero.
module lpm_scan_dwell
    import lpm_scan_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic clock,
    input  logic sclr,
    input  logic clken_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_c
);

    localparam int unsigned CNT_W = dwell_cnt_w(DWELL);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clken_i) begin
            if (load_i) begin
                cnt_d = RELOAD;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lpm_scan_seq.sv
// Index sequencer feeding lpm_decode: steps data from a latched first to last index,
// holding each index for lpm_dwell qualified cycles, once or continuously.
module lpm_scan_seq
    import lpm_scan_pkg::*;
#(
    parameter int unsigned lpm_width   = 1,
    parameter int unsigned lpm_decodes = 1 << lpm_width,
    parameter int unsigned lpm_dwell   = 1,
    parameter string       lpm_hint    = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 clken,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [lpm_width-1:0] first,
    input  logic [lpm_width-1:0] last,
    output logic [lpm_width-1:0] data,
    output logic                 enable,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output logic                 err
);

    if (lpm_dwell < 1) begin : g_bad_dwell
        $error("lpm_scan_seq (%s): lpm_dwell must be >= 1", lpm_hint);
    end

    localparam logic [lpm_width-1:0] TOP_IDX = lpm_width'(lpm_decodes - 1);

    scan_state_e          state_q, state_d;
    logic [lpm_width-1:0] data_q, data_d;
    logic [lpm_width-1:0] first_l_q, first_l_d;
    logic [lpm_width-1:0] last_l_q, last_l_d;
    logic                 mode_l_q, mode_l_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic                 dwell_load, dwell_dec, dwell_zero_c;
    logic                 range_ok_c;

    lpm_scan_dwell #(
        .DWELL(lpm_dwell)
    ) u_dwell (
        .clock  (clock),
        .sclr   (sclr),
        .clken_i(clken),
        .load_i (dwell_load),
        .dec_i  (dwell_dec),
        .zero_c (dwell_zero_c)
    );

    assign range_ok_c = (32'(first) < lpm_decodes) && (32'(last) < lpm_decodes);

    // Next-state and output decode; pulses default low and only fire on qualified edges.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        first_l_d  = first_l_q;
        last_l_d   = last_l_q;
        mode_l_d   = mode_l_q;
        enable_d   = enable_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;
        if (clken) begin
            case (state_q)
                SCAN_IDLE: begin
                    if (start && !stop) begin
                        if (range_ok_c) begin
                            first_l_d  = first;
                            last_l_d   = last;
                            mode_l_d   = mode;
                            data_d     = first;
                            enable_d   = 1'b1;
                            busy_d     = 1'b1;
                            dwell_load = 1'b1;
                            state_d    = SCAN_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN_RUN: begin
                    if (stop) begin
                        enable_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = SCAN_IDLE;
                    end else if (!dwell_zero_c) begin
                        dwell_dec = 1'b1;
                    end else if (data_q != last_l_q) begin
                        data_d     = (data_q == TOP_IDX) ? '0 : data_q + lpm_width'(1);
                        dwell_load = 1'b1;
                    end else if (mode_l_q == SCAN_CONT) begin
                        data_d     = first_l_q;
                        dwell_load = 1'b1;
                        wrap_d     = 1'b1;
                    end else begin
                        enable_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = SCAN_IDLE;
                    end
                end
                default: begin
                    state_d = SCAN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q   <= SCAN_IDLE;
            data_q    <= '0;
            first_l_q <= '0;
            last_l_q  <= '0;
            mode_l_q  <= SCAN_SINGLE;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            first_l_q <= first_l_d;
            last_l_q  <= last_l_d;
            mode_l_q  <= mode_l_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign data   = data_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

endmodule
